// File: rtl/text_field_overlay.sv
// Programmable text-field overlay: a table of positioned, coloured, scalable
// text fields mapped onto font-ROM addresses through a two-stage pixel pipeline.
module text_field_overlay #(
   parameter int NUM_FIELDS   = 16,
   parameter int MAX_CHARS    = 8,
   parameter int COLOR_W      = 4,
   parameter int BLINK_FRAMES = 30,
   localparam int FW  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
   localparam int CIW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pixel_tick,
   input  logic [9:0]         pixelx,
   input  logic [9:0]         pixely,
   input  logic               frame_start,
   input  logic               cfg_we,
   input  logic [FW-1:0]      cfg_field,
   input  logic [9:0]         cfg_x,
   input  logic [9:0]         cfg_y,
   input  logic [4:0]         cfg_len,
   input  logic [COLOR_W-1:0] cfg_color,
   input  logic               cfg_scale,
   input  logic               cfg_blink,
   input  logic               cfg_en,
   input  logic               char_we,
   input  logic [FW-1:0]      char_field,
   input  logic [CIW-1:0]     char_idx,
   input  logic [6:0]         char_code,
   output logic [10:0]        rom_addr,
   output logic [2:0]         col_addr,
   output logic [COLOR_W-1:0] color_addr,
   output logic [1:0]         font_size,
   output logic               dp
);

   logic [9:0]         fx    [NUM_FIELDS];
   logic [9:0]         fy    [NUM_FIELDS];
   logic [4:0]         flen  [NUM_FIELDS];
   logic [COLOR_W-1:0] fcol  [NUM_FIELDS];
   logic               fsc   [NUM_FIELDS];
   logic               fblk  [NUM_FIELDS];
   logic               fen   [NUM_FIELDS];
   logic [6:0]         chars [NUM_FIELDS][MAX_CHARS];

   logic [7:0]         blink_cnt;
   logic               blink_phase;

   logic [NUM_FIELDS-1:0] hit;
   logic [FW-1:0]      win;
   logic               any_hit;
   logic [9:0]         dx;
   logic [9:0]         dy;
   logic               s;

   logic               s1_hit;
   logic [FW-1:0]      s1_win;
   logic [CIW-1:0]     s1_ci;
   logic [2:0]         s1_col;
   logic [3:0]         s1_row;
   logic [COLOR_W-1:0] s1_color;
   logic               s1_scale;
   logic               s1_blank;
   logic [6:0]         code;

   logic [4:0]         len_clamped;

   assign len_clamped = (cfg_len > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : cfg_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FIELDS; i++) begin
            fx[i]   <= '0;
            fy[i]   <= '0;
            flen[i] <= '0;
            fcol[i] <= '0;
            fsc[i]  <= 1'b0;
            fblk[i] <= 1'b0;
            fen[i]  <= 1'b0;
         end
      end else if (cfg_we) begin
         fx[cfg_field]   <= cfg_x;
         fy[cfg_field]   <= cfg_y;
         flen[cfg_field] <= len_clamped;
         fcol[cfg_field] <= cfg_color;
         fsc[cfg_field]  <= cfg_scale;
         fblk[cfg_field] <= cfg_blink;
         fen[cfg_field]  <= cfg_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FIELDS; i++)
            for (int j = 0; j < MAX_CHARS; j++)
               chars[i][j] <= 7'h00;
      end else if (char_we) begin
         chars[char_field][char_idx] <= char_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 8'd1;
         end
      end
   end

   // 11-bit right edges so fields running past 1023 clip instead of wrapping
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         hit[i] = fen[i] && (flen[i] != 5'd0)
            && ({1'b0, pixelx} >= {1'b0, fx[i]})
            && ({1'b0, pixelx} <
                ({1'b0, fx[i]} + (11'(flen[i]) << (3 + 32'(fsc[i])))))
            && ({1'b0, pixely} >= {1'b0, fy[i]})
            && ({1'b0, pixely} <
                ({1'b0, fy[i]} + (11'd16 << fsc[i])));
      end
   end

   always_comb begin
      win = '0;
      for (int i = NUM_FIELDS - 1; i >= 0; i--)
         if (hit[i]) win = FW'(i);
   end

   assign any_hit = |hit;
   assign s  = fsc[win];
   assign dx = pixelx - fx[win];
   assign dy = pixely - fy[win];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit   <= 1'b0;
         s1_win   <= '0;
         s1_ci    <= '0;
         s1_col   <= '0;
         s1_row   <= '0;
         s1_color <= '0;
         s1_scale <= 1'b0;
         s1_blank <= 1'b0;
      end else if (pixel_tick) begin
         s1_hit   <= any_hit;
         s1_win   <= win;
         s1_ci    <= CIW'(dx >> (3 + 32'(s)));
         s1_col   <= 3'(dx >> s);
         s1_row   <= 4'(dy >> s);
         s1_color <= fcol[win];
         s1_scale <= s;
         s1_blank <= fblk[win] & blink_phase;
      end
   end

   assign code = chars[s1_win][s1_ci];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr   <= '0;
         col_addr   <= '0;
         color_addr <= '0;
         font_size  <= 2'd1;
         dp         <= 1'b0;
      end else if (pixel_tick) begin
         if (s1_hit) begin
            rom_addr   <= {code, s1_row};
            col_addr   <= s1_col;
            color_addr <= s1_color;
            font_size  <= s1_scale ? 2'd2 : 2'd1;
            dp         <= ~s1_blank;
         end else begin
            rom_addr   <= '0;
            col_addr   <= '0;
            color_addr <= '0;
            font_size  <= 2'd1;
            dp         <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_text_field_overlay.sv
// Directed-vector bench for text_field_overlay (16 fields, 8 chars,
// BLINK_FRAMES=2) with hand-computed expected outputs.
module tb_text_field_overlay;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pixel_tick;
   logic [9:0]  pixelx;
   logic [9:0]  pixely;
   logic        frame_start;
   logic        cfg_we;
   logic [3:0]  cfg_field;
   logic [9:0]  cfg_x;
   logic [9:0]  cfg_y;
   logic [4:0]  cfg_len;
   logic [3:0]  cfg_color;
   logic        cfg_scale;
   logic        cfg_blink;
   logic        cfg_en;
   logic        char_we;
   logic [3:0]  char_field;
   logic [2:0]  char_idx;
   logic [6:0]  char_code;
   logic [10:0] rom_addr;
   logic [2:0]  col_addr;
   logic [3:0]  color_addr;
   logic [1:0]  font_size;
   logic        dp;

   int n_cmp = 0;
   int n_err = 0;

   text_field_overlay #(
      .NUM_FIELDS(16),
      .MAX_CHARS(8),
      .COLOR_W(4),
      .BLINK_FRAMES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pixel_tick(pixel_tick),
      .pixelx(pixelx),
      .pixely(pixely),
      .frame_start(frame_start),
      .cfg_we(cfg_we),
      .cfg_field(cfg_field),
      .cfg_x(cfg_x),
      .cfg_y(cfg_y),
      .cfg_len(cfg_len),
      .cfg_color(cfg_color),
      .cfg_scale(cfg_scale),
      .cfg_blink(cfg_blink),
      .cfg_en(cfg_en),
      .char_we(char_we),
      .char_field(char_field),
      .char_idx(char_idx),
      .char_code(char_code),
      .rom_addr(rom_addr),
      .col_addr(col_addr),
      .color_addr(color_addr),
      .font_size(font_size),
      .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int ra, input int ca,
                            input int co, input int fs, input int d);
      check({tag, ".rom"}, 32'(rom_addr), 32'(ra));
      check({tag, ".col"}, 32'(col_addr), 32'(ca));
      check({tag, ".color"}, 32'(color_addr), 32'(co));
      check({tag, ".size"}, 32'(font_size), 32'(fs));
      check({tag, ".dp"}, 32'(dp), 32'(d));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int f, input int x, input int y,
                          input int len, input int col, input int sc,
                          input int bl, input int en);
      cfg_field = 4'(f);
      cfg_x     = 10'(x);
      cfg_y     = 10'(y);
      cfg_len   = 5'(len);
      cfg_color = 4'(col);
      cfg_scale = 1'(sc);
      cfg_blink = 1'(bl);
      cfg_en    = 1'(en);
   endtask

   task automatic cfg(input int f, input int x, input int y, input int len,
                      input int col, input int sc, input int bl, input int en);
      set_cfg(f, x, y, len, col, sc, bl, en);
      cfg_we = 1'b1;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic wch(input int f, input int idx, input int code);
      char_field = 4'(f);
      char_idx   = 3'(idx);
      char_code  = 7'(code);
      char_we    = 1'b1;
      cyc();
      char_we    = 1'b0;
   endtask

   task automatic pix(input int x, input int y);
      pixelx     = 10'(x);
      pixely     = 10'(y);
      pixel_tick = 1'b1;
      cyc();
      cyc();
      pixel_tick = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
   endtask

   initial begin
      logic exp_dp [4];
      exp_dp = '{1'b0, 1'b0, 1'b1, 1'b1};
      rst_n = 1'b0;
      pixel_tick = 1'b0;
      pixelx = '0;
      pixely = '0;
      frame_start = 1'b0;
      cfg_we = 1'b0;
      char_we = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
      char_field = '0;
      char_idx = '0;
      char_code = '0;
      cyc();
      cyc();
      check_out("in_reset", 0, 0, 0, 1, 0);
      rst_n = 1'b1;
      cyc();
      pix(10, 10);
      check_out("post_reset_a", 0, 0, 0, 1, 0);
      pix(600, 400);
      check_out("post_reset_b", 0, 0, 0, 1, 0);

      cfg(0, 300, 240, 2, 2, 0, 0, 1);
      wch(0, 0, 'h31);
      wch(0, 1, 'h37);
      pix(309, 245);
      check_out("f0_hit", 'h375, 1, 2, 1, 1);
      pix(316, 245);
      check_out("f0_right_edge", 0, 0, 0, 1, 0);
      pix(300, 256);
      check_out("f0_bottom_edge", 0, 0, 0, 1, 0);
      pix(300, 240);
      check_out("f0_origin", 'h310, 0, 2, 1, 1);

      pixelx = 10'd309;
      pixely = 10'd245;
      pixel_tick = 1'b1;
      cyc();
      pixelx = 10'd316;
      cyc();
      pixel_tick = 1'b0;
      check_out("latency_a", 'h375, 1, 2, 1, 1);
      pixel_tick = 1'b1;
      cyc();
      pixel_tick = 1'b0;
      check_out("latency_b", 0, 0, 0, 1, 0);
      pixelx = 10'd300;
      pixely = 10'd240;
      cyc();
      cyc();
      cyc();
      check_out("hold", 0, 0, 0, 1, 0);

      cfg(3, 100, 100, 1, 3, 1, 0, 1);
      wch(3, 0, 'h41);
      pix(115, 131);
      check_out("f3_2x", 'h41f, 7, 3, 2, 1);
      pix(116, 131);
      check_out("f3_right_edge", 0, 0, 0, 1, 0);

      cfg(1, 500, 300, 1, 5, 0, 0, 1);
      wch(1, 0, 'h41);
      cfg(5, 500, 300, 1, 9, 0, 0, 1);
      wch(5, 0, 'h42);
      pix(503, 302);
      check_out("overlap_f1", 'h412, 3, 5, 1, 1);
      cfg(1, 500, 300, 1, 5, 0, 0, 0);
      pix(503, 302);
      check_out("overlap_f5", 'h422, 3, 9, 1, 1);

      set_cfg(2, 600, 400, 20, 1, 0, 0, 1);
      char_field = 4'd2;
      char_idx = 3'd7;
      char_code = 7'h5a;
      cfg_we = 1'b1;
      char_we = 1'b1;
      cyc();
      cfg_we = 1'b0;
      char_we = 1'b0;
      pix(663, 400);
      check_out("clamp_last", 'h5a0, 7, 1, 1, 1);
      pix(664, 400);
      check_out("clamp_edge", 0, 0, 0, 1, 0);

      cfg(7, 300, 240, 2, 7, 0, 0, 1);
      cfg(0, 300, 240, 2, 2, 0, 1, 1);
      pix(309, 245);
      check_out("blink_f0", 'h375, 1, 2, 1, 1);
      pixelx = 10'd309;
      pixely = 10'd245;
      frame_start = 1'b1;
      pixel_tick = 1'b1;
      cyc();
      frame_start = 1'b0;
      cyc();
      pixel_tick = 1'b0;
      check("blink_f1.dp", 32'(dp), 32'd1);
      for (int k = 0; k < 4; k++) begin
         frame();
         pix(309, 245);
         check($sformatf("blink_f%0d.dp", k + 2), 32'(dp), 32'(exp_dp[k]));
         check($sformatf("blink_f%0d.color", k + 2), 32'(color_addr), 32'd2);
         check($sformatf("blink_f%0d.rom", k + 2), 32'(rom_addr), 32'h375);
      end
      frame();
      pix(309, 245);
      check("blink_f6.dp", 32'(dp), 32'd0);

      rst_n = 1'b0;
      #1;
      check_out("mid_reset", 0, 0, 0, 1, 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      pix(309, 245);
      check_out("after_reset_cleared", 0, 0, 0, 1, 0);
      cfg(0, 300, 240, 2, 2, 0, 1, 1);
      wch(0, 1, 'h37);
      pix(309, 245);
      check_out("after_reset_phase0", 'h375, 1, 2, 1, 1);
      frame();
      pix(309, 245);
      check("after_reset_fr1.dp", 32'(dp), 32'd1);
      frame();
      pix(309, 245);
      check("after_reset_fr2.dp", 32'(dp), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
